// File: rtl/dma_master_if.sv
// ============================================================================
// Module   : dma_master_if
// Function : Command, source, read-return and arbitrated bus signals of one
//            DMA channel master, with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dma_master_if #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int LW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_pop;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          dma;
    logic          grant;
    logic          ready;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_dout;
    logic [DW-1:0] bus_din;
    logic          bus_we;
    logic          bus_oe;
    logic          done;
    logic          err;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  src_data, src_valid, grant, ready, bus_din,
        output cmd_ready, src_pop, rd_data, rd_valid, dma,
        output bus_addr, bus_dout, bus_we, bus_oe, done, err
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output src_data, src_valid, grant, ready, bus_din,
        input  cmd_ready, src_pop, rd_data, rd_valid, dma,
        input  bus_addr, bus_dout, bus_we, bus_oe, done, err
    );
endinterface

`default_nettype wire

// File: rtl/dma_master.sv
// ============================================================================
// Module   : dma_master
// Function : Bus master for one DMA channel; requests the bus per beat and
//            re-arbitrates between beats. DMA_TIMEOUT_EN adds a ready timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dma_master #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int LW = 8
`ifdef DMA_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  wire logic    clk,
    input  wire logic    clr,
    dma_master_if.master bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_cnt;
    logic          r_write;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;

    logic w_busy;
    logic w_beat;
    logic w_last;
    logic w_timeout;

    assign w_busy = (r_state == c_ST_BUSY);
    // A write beat is never completed without source data behind it.
    assign w_beat = w_busy & bus.grant & bus.ready & (~r_write | bus.src_valid);
    assign w_last = (r_cnt == '0);

    assign bus.cmd_ready = (r_state == c_ST_IDLE);
    assign bus.dma       = w_busy & (~r_write | bus.src_valid);
    assign bus.bus_oe    = w_busy & bus.grant;
    assign bus.bus_we    = w_busy & bus.grant & r_write;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_dout  = bus.src_data;
    assign bus.src_pop   = w_beat & r_write;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.done      = (r_state == c_ST_DONE);

`ifdef DMA_TIMEOUT_EN
    localparam int c_TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [c_TW-1:0] r_to_cnt;
    logic            r_err;
    logic            w_stall;

    assign w_stall   = w_busy & bus.grant & ~bus.ready;
    assign w_timeout = w_stall & (r_to_cnt == c_TW'(TIMEOUT - 1));
    assign bus.err   = r_err;

    // r_err is only ever set on the transition into the one-cycle DONE state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (!w_busy || w_beat) begin
                r_to_cnt <= '0;
            end else if (w_stall) begin
                r_to_cnt <= r_to_cnt + c_TW'(1);
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= c_ST_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_addr  <= bus.cmd_addr;
                        r_cnt   <= bus.cmd_len;
                        r_write <= bus.cmd_write;
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (w_timeout) begin
                        r_state <= c_ST_DONE;
                    end else if (w_beat) begin
                        r_addr <= r_addr + AW'(1);
                        if (!r_write) begin
                            r_rd_data  <= bus.bus_din;
                            r_rd_valid <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_cnt <= r_cnt - LW'(1);
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_master.sv
// ============================================================================
// Module   : tb_dma_master
// Function : Scoreboard bench for dma_master; define DMA_TIMEOUT_EN to
//            exercise the timeout abort with TIMEOUT=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dma_master;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } beat_t;

    logic clk;
    logic clr;
    logic gnt_en, ready_en, src_en, to_mode;
    logic [7:0] src_idx, push_idx;

    int n_vec, n_miss;
    int beats_seen, burst_left, rd_cnt, pop_cnt, done_cnt, cyc;
    int first_fire, last_fire;

    beat_t      beat_q[$];
    logic [7:0] rd_q[$];

    dma_master_if #(.AW(16), .DW(8), .LW(8)) bus_if ();

    dma_master #(
        .AW(16), .DW(8), .LW(8)
`ifdef DMA_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if.master)
    );

    function automatic logic [7:0] mem_at(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    assign bus_if.grant     = bus_if.dma & gnt_en;
    assign bus_if.ready     = bus_if.grant & ready_en;
    assign bus_if.bus_din   = mem_at(bus_if.bus_addr);
    assign bus_if.src_data  = 8'h30 + src_idx;
    assign bus_if.src_valid = src_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, advances the source after the rising edge.
    initial begin : mon
        logic  fire, exp_rd, exp_done, pend;
        beat_t b;
        exp_rd = 1'b0; exp_done = 1'b0; pend = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            pend = 1'b0;
            if (bus_if.done) done_cnt++;
            if (clr) begin
                exp_rd = 1'b0; exp_done = 1'b0;
            end else begin
                if (bus_if.rd_valid || exp_rd) begin
                    chk("rd_valid", bus_if.rd_valid, exp_rd);
                    if (exp_rd) begin
                        rd_cnt++;
                        if (rd_q.size() == 0) chk("rd_sb_empty", 0, 1);
                        else chk("rd_data", bus_if.rd_data, rd_q.pop_front());
                    end
                end
                if (!to_mode && (bus_if.done || exp_done)) begin
                    chk("done", bus_if.done, exp_done);
                    if (exp_done) begin
                        chk("dma_after_last", bus_if.dma, 0);
                        chk("err_normal", bus_if.err, 0);
                    end
                end
                fire = bus_if.bus_oe && bus_if.ready;
                if (fire || bus_if.src_pop)
                    chk("src_pop", bus_if.src_pop, fire && bus_if.bus_we);
                if (fire) begin
                    if (first_fire < 0) first_fire = cyc;
                    last_fire = cyc;
                    beats_seen++;
                    burst_left--;
                    if (bus_if.bus_we) begin
                        pop_cnt++;
                        pend = 1'b1;
                    end
                    if (beat_q.size() == 0) begin
                        chk("beat_sb_empty", 0, 1);
                    end else begin
                        b = beat_q.pop_front();
                        chk("bus_addr", bus_if.bus_addr, b.addr);
                        chk("bus_we", bus_if.bus_we, b.we);
                        if (b.we) chk("bus_dout", bus_if.bus_dout, b.data);
                    end
                end
                exp_rd   = fire && !bus_if.bus_we;
                exp_done = fire && (burst_left == 0);
            end
            @(posedge clk);
            #1;
            if (pend) src_idx++;
        end
    end

    task automatic start_test();
        beats_seen = 0; rd_cnt = 0; pop_cnt = 0; done_cnt = 0; first_fire = -1; last_fire = -1;
    endtask

    task automatic flush();
        beat_q.delete();
        rd_q.delete();
        burst_left = 0;
        push_idx   = src_idx;
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] len);
        beat_t b;
        bit    ok;
        for (int i = 0; i <= int'(len); i++) begin
            b.addr = a + 16'(i);
            b.we   = wr;
            b.data = 8'h00;
            if (wr) begin
                b.data = 8'h30 + push_idx;
                push_idx++;
            end else begin
                rd_q.push_back(mem_at(b.addr));
            end
            beat_q.push_back(b);
        end
        burst_left = int'(len) + 1;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus_if.cmd_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("cmd_ready_wait", 0, 1);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = wr;
        bus_if.cmd_addr  = a;
        bus_if.cmd_len   = len;
        @(posedge clk); #1;
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (beats_seen >= n) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("beat_wait", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (burst_left == 0 && bus_if.cmd_ready && !bus_if.done) begin ok = 1; break; end
        end
        if (!ok) chk("idle_wait", 0, 1);
        chk("sb_left", beat_q.size(), 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; ready_en = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0; ready_en = 1'b1;
        flush();
    endtask

    task automatic chk_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_dma"}, bus_if.dma, 0);
        chk({tag, "_oe"}, bus_if.bus_oe, 0);
        chk({tag, "_we"}, bus_if.bus_we, 0);
        chk({tag, "_pop"}, bus_if.src_pop, 0);
        chk({tag, "_rdv"}, bus_if.rd_valid, 0);
        chk({tag, "_done"}, bus_if.done, 0);
        chk({tag, "_err"}, bus_if.err, 0);
        chk({tag, "_rdd"}, bus_if.rd_data, 0);
        chk({tag, "_addr"}, bus_if.bus_addr, 0);
        chk({tag, "_cmdrdy"}, bus_if.cmd_ready, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        n_vec = 0; n_miss = 0; burst_left = 0;
        clr = 1'b1; gnt_en = 1'b1; ready_en = 1'b1; src_en = 1'b1; to_mode = 1'b0;
        src_idx = 8'h00; push_idx = 8'h00;
        bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr = '0; bus_if.cmd_len = '0;
        start_test();
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        chk_idle_outputs("reset");

        // Single read from 0x1000.
        @(posedge clk); #1;
        start_test();
        issue(1'b0, 16'h1000, 8'd0);
        wait_idle();
        chk("rd1_count", rd_cnt, 1);
        chk("rd1_done_cnt", done_cnt, 1);

        // Four-beat write with a two-cycle source gap before beat 3.
        start_test();
        issue(1'b1, 16'h2000, 8'd3);
        wait_beats(2);
        src_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("gap_dma", bus_if.dma, 0);
        end
        @(posedge clk); #1 src_en = 1'b1;
        wait_idle();
        chk("wr_pop_cnt", pop_cnt, 4);
        chk("wr_done_cnt", done_cnt, 1);

        // Three-beat read pre-empted for five cycles after beat 1.
        start_test();
        issue(1'b0, 16'h3400, 8'd2);
        wait_beats(1);
        gnt_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("preempt_dma", bus_if.dma, 1);
            chk("preempt_oe", bus_if.bus_oe, 0);
        end
        @(posedge clk); #1 gnt_en = 1'b1;
        wait_idle();
        chk("preempt_rd_cnt", rd_cnt, 3);

        // Address wrap, back-to-back beats.
        start_test();
        issue(1'b0, 16'hFFFE, 8'd2);
        wait_idle();
        chk("wrap_span", last_fire - first_fire, 2);
        chk("wrap_rd_cnt", rd_cnt, 3);

        // Reset during beat 2 of a four-beat write.
        start_test();
        issue(1'b1, 16'h4000, 8'd3);
        wait_beats(1);
        pulse_clr();
        chk_idle_outputs("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_done_cnt", done_cnt, 0);
        @(posedge clk); #1;
        start_test();
        issue(1'b1, 16'h4100, 8'd1);
        wait_idle();
        chk("post_rst_pop_cnt", pop_cnt, 2);
        chk("post_rst_done_cnt", done_cnt, 1);

        // Granted but ready held low.
        start_test();
        to_mode = 1'b1; ready_en = 1'b0;
        issue(1'b0, 16'h5000, 8'd1);
`ifdef DMA_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_wait_oe", bus_if.bus_oe, 1);
            chk("to_wait_done", bus_if.done, 0);
        end
        @(negedge clk);
        chk("to_done", bus_if.done, 1);
        chk("to_err", bus_if.err, 1);
        chk("to_dma", bus_if.dma, 0);
        chk("to_oe", bus_if.bus_oe, 0);
        @(posedge clk); #1;
        ready_en = 1'b1;
        flush();
        @(negedge clk);
        chk("to_idle_err", bus_if.err, 0);
        chk("to_idle_rdy", bus_if.cmd_ready, 1);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("nto_err", bus_if.err, 0);
            chk("nto_done", bus_if.done, 0);
            chk("nto_dma", bus_if.dma, 1);
        end
        @(posedge clk); #1;
        pulse_clr();
        chk_idle_outputs("nto_rst");
`endif
        to_mode = 1'b0;

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
